// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  // Sequencer states: wait for a request, shift bits, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Operand/sum width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign S       = a_xor_b ^ Cin;
  assign Cout    = (A & B) | (Cin & a_xor_b);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one Full_Adder reused LSB first over WIDTH
// cycles, with a registered carry and a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit index counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  sa_state_t        state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_cout;

  // Operand LSBs and the registered carry feed the single shared adder bit.
  Full_Adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_LAST);

  // Handshake outputs are pure state decodes.
  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  // Next-state decode: start is only honoured from IDLE, DONE lasts one cycle.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next; without it a latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: capture operands on accepted start, then shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) cout <= fa_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the handshake,
// carry, ignored-start and reset cases, and a 2-bit instance swept exhaustively.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       reset;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2;
  logic [1:0] sum2;
  logic       cout2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit transaction. Optionally pulse start with 0xFF+0xFF at sample
  // index inject_at while the DUT is busy; that request must be ignored.
  task automatic run8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                      input logic cin_v, input logic [7:0] exp_sum, input logic exp_cout,
                      input int inject_at);
    int         n_busy;
    int         n_done;
    int         done_at;
    logic [7:0] sum_at_done;
    logic       cout_at_done;
    n_busy = 0; n_done = 0; done_at = -1;
    sum_at_done = '0; cout_at_done = 1'b0;
    a8 = a_v; b8 = b_v; cin8 = cin_v; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == inject_at) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (busy8) n_busy++;
      if (done8) begin
        n_done++;
        done_at      = k;
        sum_at_done  = sum8;
        cout_at_done = cout8;
      end
      step();
    end
    start8 = 1'b0;
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_done_lat"}, done_at, 8);
    check({tag, "_busy_cyc"}, n_busy, 9);
    check({tag, "_sum"},      sum_at_done, exp_sum);
    check({tag, "_cout"},     cout_at_done, exp_cout);
    check({tag, "_sum_hold"}, {cout8, sum8}, {exp_cout, exp_sum});
  endtask

  initial begin
    int n_done;
    int lat;

    reset  = 1'b1;
    start8 = 1'b1;  // start together with reset: reset must win
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    start2 = 1'b0;
    a2 = '0; b2 = '0; cin2 = 1'b0;
    step();
    step();
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_sum8",  sum8,  8'h00);
    check("rst_cout8", cout8, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_sum2",  {cout2, sum2}, 3'b000);
    start8 = 1'b0;
    reset  = 1'b0;
    step();

    // Zero operands, full carry ripple, no-carry MSB, carry-in paths.
    run8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    run8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    run8("msb",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1);
    run8("alt",    8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
    run8("cin",    8'h12, 8'h34, 1'b1, 8'h47, 1'b0, -1);
    // Start pulsed on the third busy cycle is ignored.
    run8("ignore", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2);

    // Reset on the fourth cycle of a RUN aborts with no done pulse.
    a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    check("abort_busy_pre", busy8, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_sum",  sum8,  8'h00);
    check("abort_cout", cout8, 1'b0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) n_done++;
      step();
    end
    check("abort_no_done", n_done, 0);
    run8("fresh", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, -1);

    // WIDTH=2 exhaustive back-to-back sweep: start in the IDLE cycle after done.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
      step();
      start2 = 1'b0;
      check("w2_accept", busy2, 1'b1);
      lat = 0;
      while (!done2 && lat < 8) begin
        step();
        lat++;
      end
      check("w2_lat", lat, 2);
      check("w2_sum", {cout2, sum2}, 32'(v[4:3]) + 32'(v[2:1]) + 32'(v[0]));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
